// File: rtl/gate_sweep_checker.sv
// Stimulus/response checker for the two-input gate bank: walks {a,b} through
// 00,01,10,11, samples the seven gate outputs after a settle time and keeps error stats.
module gate_sweep_checker #(
  parameter int SETTLE = 2,
  parameter int SWEEPS = 1,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a,
  output logic             b,
  input  logic [6:0]       gates,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [6:0]       err_mask,
  output logic [1:0]       first_fail_ab,
  output logic             first_fail_valid
);

  localparam int WAIT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int SWP_W  = (SWEEPS > 1) ? $clog2(SWEEPS) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LOAD  = WAIT_W'(SETTLE - 1);
  localparam logic [SWP_W-1:0]  LAST_SWEEP = SWP_W'(SWEEPS - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_CHECK, ST_DONE} state_t;

  state_t            state;
  state_t            state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic [1:0]        idx;
  logic [SWP_W-1:0]  sweep;
  logic [6:0]        expected;
  logic [6:0]        mism;
  logic              busy_next;
  logic              done_next;
  logic              last_vector;

  // The vector index register is the drive itself, so a/b come straight off flops.
  assign a = idx[1];
  assign b = idx[0];

  assign last_vector = (idx == 2'd3) && (sweep == LAST_SWEEP);

  always_comb begin
    expected = {a ^ b, ~a, ~(a ^ b), ~(a | b), ~(a & b), a | b, a & b};
    mism     = gates ^ expected;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= busy_next;
      done  <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start) state_next = ST_WAIT;
      ST_WAIT:  if (wait_cnt == '0) state_next = ST_CHECK;
      ST_CHECK: state_next = last_vector ? ST_DONE : ST_WAIT;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // busy/done are decoded from the next state so they can be registered without lag.
  always_comb begin
    busy_next = (state_next == ST_WAIT) || (state_next == ST_CHECK);
    done_next = (state_next == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx              <= 2'd0;
      sweep            <= '0;
      wait_cnt         <= '0;
      pass             <= 1'b0;
      err_count        <= '0;
      err_mask         <= 7'd0;
      first_fail_ab    <= 2'd0;
      first_fail_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            idx              <= 2'd0;
            sweep            <= '0;
            wait_cnt         <= WAIT_LOAD;
            pass             <= 1'b0;
            err_count        <= '0;
            err_mask         <= 7'd0;
            first_fail_ab    <= 2'd0;
            first_fail_valid <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (wait_cnt != '0) wait_cnt <= wait_cnt - WAIT_W'(1);
        end
        ST_CHECK: begin
          if (mism != 7'd0) begin
            err_mask <= err_mask | mism;
            if (err_count != CNT_MAX) err_count <= err_count + CNT_W'(1);
            if (!first_fail_valid) begin
              first_fail_ab    <= idx;
              first_fail_valid <= 1'b1;
            end
          end
          wait_cnt <= WAIT_LOAD;
          if (idx != 2'd3) begin
            idx <= idx + 2'd1;
          end else if (sweep != LAST_SWEEP) begin
            sweep <= sweep + SWP_W'(1);
            idx   <= 2'd0;
          end else begin
            pass <= !first_fail_valid && (mism == 7'd0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: two instances (long settle / saturating counter) driven by a
// faultable gate-bank model, with a run-level scoreboard and a cycle-timing monitor.
module tb_gate_sweep_checker;

  localparam int S0 = 2, SW0 = 1, W0 = 8;
  localparam int S1 = 1, SW1 = 2, W1 = 2;

  typedef struct {
    int         errs;
    logic [6:0] mask;
    logic [1:0] ffab;
    logic       ffv;
    logic       pass;
  } result_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start_s [2];
  logic [6:0] stuck_m [2];
  logic [6:0] stuck_v [2];
  logic [6:0] inv_m [2];

  logic a0, b0, busy0, done0, pass0, ffv0;
  logic a1, b1, busy1, done1, pass1, ffv1;
  logic [7:0] errc0;
  logic [1:0] errc1;
  logic [6:0] mask0, mask1, gates0, gates1;
  logic [1:0] ffab0, ffab1;

  logic       o_a [2], o_b [2], o_busy [2], o_done [2], o_pass [2], o_ffv [2];
  logic [7:0] o_err [2];
  logic [6:0] o_mask [2];
  logic [1:0] o_ffab [2];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int e0 [2];
  bit active [2];
  result_t sb0 [$];
  result_t sb1 [$];

  always #5 clk = ~clk;

  gate_sweep_checker #(.SETTLE(S0), .SWEEPS(SW0), .CNT_W(W0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .a(a0), .b(b0), .gates(gates0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(errc0), .err_mask(mask0),
    .first_fail_ab(ffab0), .first_fail_valid(ffv0)
  );

  gate_sweep_checker #(.SETTLE(S1), .SWEEPS(SW1), .CNT_W(W1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .a(a1), .b(b1), .gates(gates1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(errc1), .err_mask(mask1),
    .first_fail_ab(ffab1), .first_fail_valid(ffv1)
  );

  function automatic int settle_of(input int d);
    return (d == 0) ? S0 : S1;
  endfunction

  function automatic int sweeps_of(input int d);
    return (d == 0) ? SW0 : SW1;
  endfunction

  function automatic int width_of(input int d);
    return (d == 0) ? W0 : W1;
  endfunction

  function automatic int run_len(input int d);
    return 4 * sweeps_of(d) * (settle_of(d) + 1);
  endfunction

  // Truth tables indexed by {a,b}, gate order AND, OR, NAND, NOR, XNOR, NOT-A, XOR.
  function automatic logic truth(input int g, input logic va, input logic vb);
    logic [3:0] tt;
    case (g)
      0: tt = 4'b1000;
      1: tt = 4'b1110;
      2: tt = 4'b0111;
      3: tt = 4'b0001;
      4: tt = 4'b1001;
      5: tt = 4'b0011;
      default: tt = 4'b0110;
    endcase
    return tt[{va, vb}];
  endfunction

  function automatic logic [6:0] good_word(input logic va, input logic vb);
    logic [6:0] w;
    for (int g = 0; g < 7; g++) w[g] = truth(g, va, vb);
    return w;
  endfunction

  function automatic logic [6:0] bank(input logic va, input logic vb,
                                     input logic [6:0] sm, input logic [6:0] sv,
                                     input logic [6:0] im);
    return ((good_word(va, vb) & ~sm) | (sv & sm)) ^ im;
  endfunction

  function automatic result_t predict(input int d);
    result_t r;
    int cnt = 0;
    int maxv = (1 << width_of(d)) - 1;
    logic [1:0] v2;
    logic [6:0] m;
    r.mask = 7'd0;
    r.ffab = 2'd0;
    r.ffv  = 1'b0;
    for (int s = 0; s < sweeps_of(d); s++) begin
      for (int v = 0; v < 4; v++) begin
        v2 = 2'(v);
        m = bank(v2[1], v2[0], stuck_m[d], stuck_v[d], inv_m[d]) ^ good_word(v2[1], v2[0]);
        if (m != 7'd0) begin
          cnt++;
          r.mask |= m;
          if (!r.ffv) begin
            r.ffv  = 1'b1;
            r.ffab = v2;
          end
        end
      end
    end
    r.errs = (cnt > maxv) ? maxv : cnt;
    r.pass = (cnt == 0);
    return r;
  endfunction

  always_comb begin
    gates0 = bank(a0, b0, stuck_m[0], stuck_v[0], inv_m[0]);
    gates1 = bank(a1, b1, stuck_m[1], stuck_v[1], inv_m[1]);
  end

  always_comb begin
    o_a[0] = a0;       o_a[1] = a1;
    o_b[0] = b0;       o_b[1] = b1;
    o_busy[0] = busy0; o_busy[1] = busy1;
    o_done[0] = done0; o_done[1] = done1;
    o_pass[0] = pass0; o_pass[1] = pass1;
    o_ffv[0] = ffv0;   o_ffv[1] = ffv1;
    o_err[0] = errc0;  o_err[1] = {6'd0, errc1};
    o_mask[0] = mask0; o_mask[1] = mask1;
    o_ffab[0] = ffab0; o_ffab[1] = ffab1;
  end

  task automatic checkOutput(input string name, input int d, input logic [31:0] got,
                             input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL dut%0d %s: got %0h, expected %0h (cycle %0d)", d, name, got, exp, cyc);
    end
  endtask

  // Run tracker: notes the edge that accepts start and queues the predicted run result.
  initial begin
    active[0] = 1'b0;
    active[1] = 1'b0;
    e0[0] = 0;
    e0[1] = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        active[0] = 1'b0;
        active[1] = 1'b0;
        sb0.delete();
        sb1.delete();
      end else begin
        cyc++;
        for (int d = 0; d < 2; d++) begin
          if (active[d]) begin
            if (cyc == e0[d] + run_len(d) + 1) active[d] = 1'b0;
          end else if (start_s[d]) begin
            active[d] = 1'b1;
            e0[d] = cyc;
            if (d == 0) sb0.push_back(predict(0));
            else sb1.push_back(predict(1));
          end
        end
      end
    end
  end

  // Monitor: samples on the falling edge, checks timing every cycle and the result on done.
  initial begin
    int c, t, k;
    logic [1:0] vec;
    result_t r;
    bit have;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!rst_n) begin
          checkOutput("reset a/b", d, {30'd0, o_a[d], o_b[d]}, 32'd0);
          checkOutput("reset busy/done/pass", d, {29'd0, o_busy[d], o_done[d], o_pass[d]}, 32'd0);
          checkOutput("reset err_count", d, {24'd0, o_err[d]}, 32'd0);
          checkOutput("reset err_mask", d, {25'd0, o_mask[d]}, 32'd0);
          checkOutput("reset first_fail", d, {29'd0, o_ffv[d], o_ffab[d]}, 32'd0);
        end else if (active[d]) begin
          c = cyc - e0[d];
          t = run_len(d);
          if (c < t) begin
            k = c / (settle_of(d) + 1);
            vec = 2'(k % 4);
            checkOutput("busy in run", d, {31'd0, o_busy[d]}, 32'd1);
            checkOutput("done in run", d, {31'd0, o_done[d]}, 32'd0);
            checkOutput("pass in run", d, {31'd0, o_pass[d]}, 32'd0);
            checkOutput("a/b vector", d, {30'd0, o_a[d], o_b[d]}, {30'd0, vec});
            if (c == 0) begin
              checkOutput("cleared err_count", d, {24'd0, o_err[d]}, 32'd0);
              checkOutput("cleared err_mask", d, {25'd0, o_mask[d]}, 32'd0);
              checkOutput("cleared first_fail", d, {29'd0, o_ffv[d], o_ffab[d]}, 32'd0);
            end
          end else if (c == t) begin
            checkOutput("busy at end", d, {31'd0, o_busy[d]}, 32'd0);
            checkOutput("done at end", d, {31'd0, o_done[d]}, 32'd1);
            checkOutput("a/b hold", d, {30'd0, o_a[d], o_b[d]}, 32'd3);
            have = (d == 0) ? (sb0.size() != 0) : (sb1.size() != 0);
            checkOutput("scoreboard entry", d, {31'd0, have}, 32'd1);
            if (have) begin
              r = (d == 0) ? sb0.pop_front() : sb1.pop_front();
              checkOutput("err_count", d, {24'd0, o_err[d]}, 32'(r.errs));
              checkOutput("err_mask", d, {25'd0, o_mask[d]}, {25'd0, r.mask});
              checkOutput("first_fail_valid", d, {31'd0, o_ffv[d]}, {31'd0, r.ffv});
              checkOutput("first_fail_ab", d, {30'd0, o_ffab[d]}, {30'd0, r.ffab});
              checkOutput("pass", d, {31'd0, o_pass[d]}, {31'd0, r.pass});
            end
          end
        end else begin
          checkOutput("idle busy/done", d, {30'd0, o_busy[d], o_done[d]}, 32'd0);
        end
      end
    end
  end

  // One run on instance d with the given fault; poke sprinkles start pulses mid-run.
  task automatic applyStimulus(input int d, input logic [6:0] sm, input logic [6:0] sv,
                               input logic [6:0] im, input bit poke);
    int n = 0;
    stuck_m[d] = sm;
    stuck_v[d] = sv;
    inv_m[d]   = im;
    @(posedge clk);
    #2 start_s[d] = 1'b1;
    @(posedge clk);
    #2 start_s[d] = 1'b0;
    while (active[d] && n < 300) begin
      @(posedge clk);
      #2 start_s[d] = poke ? ($urandom_range(0, 2) == 0) : 1'b0;
      n++;
    end
    start_s[d] = 1'b0;
    if (n >= 300) begin
      tests++;
      fails++;
      $display("[TB] FAIL dut%0d run timeout: got still active, expected end within 300 cycles", d);
    end
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic resetMidRun();
    int n = 0;
    stuck_m[0] = 7'h00;
    stuck_v[0] = 7'h00;
    inv_m[0]   = 7'h04;
    @(posedge clk);
    #2 start_s[0] = 1'b1;
    @(posedge clk);
    #2 start_s[0] = 1'b0;
    while (active[0] && (cyc - e0[0]) < 2 * (S0 + 1) + 1 && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    inv_m[0] = 7'h00;
    repeat (30) @(posedge clk);
    #2;
    applyStimulus(0, 7'h00, 7'h00, 7'h00, 1'b0);
  endtask

  initial begin
    int d;
    logic [6:0] sm, sv, im;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0;
      stuck_m[i] = 7'h00;
      stuck_v[i] = 7'h00;
      inv_m[i]   = 7'h00;
    end
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #2;

    applyStimulus(0, 7'h00, 7'h00, 7'h00, 1'b0);
    applyStimulus(0, 7'h40, 7'h00, 7'h00, 1'b0);
    applyStimulus(1, 7'h00, 7'h00, 7'h7F, 1'b0);
    applyStimulus(0, 7'h09, 7'h01, 7'h00, 1'b1);
    applyStimulus(0, 7'h00, 7'h00, 7'h00, 1'b1);
    applyStimulus(1, 7'h00, 7'h00, 7'h00, 1'b1);
    resetMidRun();

    for (int i = 0; i < 12; i++) begin
      d  = int'($urandom_range(0, 1));
      sm = 7'h00;
      sv = 7'h00;
      im = 7'h00;
      case ($urandom_range(0, 3))
        0: ;
        1: begin
          sm = 7'(1 << $urandom_range(0, 6));
          sv = 7'($urandom);
        end
        2: im = 7'($urandom);
        default: begin
          sm = 7'($urandom);
          sv = 7'($urandom);
          im = 7'($urandom);
        end
      endcase
      applyStimulus(d, sm, sv, im, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before 1000000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
